serializador_10bits: RTL and testbench

SERIALIZADOR_10BITS -- requirements
Module: serializador_10bits

---
 rtl/serializador_10bits.sv | 84 ++++++++
 tb/tb_serializador_10bits.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serializador_10bits.sv
// serializador_10bits: serializes one parallel word per frame with a programmable bit period,
// driving a downstream shift register through ser_out, shift_en and dir.
module serializador_10bits #(
    parameter int WIDTH = 10,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic             msb_first,
    input  logic [DIV_W-1:0] div,
    output logic             ser_out,
    output logic             shift_en,
    output logic             dir,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [DIV_W-1:0] div_q, div_d, presc_q, presc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_q, ser_d, shift_en_q, shift_en_d, dir_q, dir_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             accept, last, strobe;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            div_q      <= '0;
            presc_q    <= '0;
            cnt_q      <= '0;
            ser_q      <= 1'b0;
            shift_en_q <= 1'b0;
            dir_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            div_q      <= div_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            ser_q      <= ser_d;
            shift_en_q <= shift_en_d;
            dir_q      <= dir_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        accept  = state_q == IDLE && start;
        last    = cnt_q == CW'(WIDTH);
        state_d = state_q == IDLE  ? (start ? SHIFT : IDLE) :
                  state_q == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    end

    // dir_q doubles as the captured bit order: the shifter always emits from the end facing dir
    always_comb begin
        strobe     = state_q == SHIFT && !last && presc_q == '0;
        sh_d       = accept ? data : strobe ? (dir_q ? sh_q << 1 : sh_q >> 1) : sh_q;
        ser_d      = strobe ? (dir_q ? sh_q[WIDTH-1] : sh_q[0]) : ser_q;
        div_d      = accept ? div : div_q;
        presc_d    = accept ? div : strobe ? div_q :
                     (state_q == SHIFT && presc_q != '0) ? presc_q - DIV_W'(1) : presc_q;
        cnt_d      = accept ? '0 : strobe ? cnt_q + CW'(1) : cnt_q;
        shift_en_d = strobe;
        dir_d      = accept ? msb_first : dir_q;
        busy_d     = state_d == SHIFT;
        done_d     = state_d == DONE;
    end

    assign ser_out  = ser_q;
    assign shift_en = shift_en_q;
    assign dir      = dir_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_serializador_10bits.sv
// tb_serializador_10bits: frame-level model plus downstream shift register, checked every cycle,
// with directed frames carrying hand-computed sequences and timings.
module tb_serializador_10bits;
    localparam int W  = 10;
    localparam int DW = 8;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, msb_first = 1'b0;
    logic [W-1:0]  data = '0;
    logic [DW-1:0] div = '0;
    logic          ser_out, shift_en, dir, busy, done;

    int tests = 0, fails = 0, cyc = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    serializador_10bits #(.WIDTH(W), .DIV_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .msb_first(msb_first), .div(div),
        .ser_out(ser_out), .shift_en(shift_en), .dir(dir), .busy(busy), .done(done)
    );

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Frame model: position n (edges since acceptance) decides everything
    logic [W-1:0] cd;
    logic         cm;
    int           cp, n;
    bit           active = 0;
    logic         e_ser = 0, e_sh = 0, e_dir = 0, e_busy = 0, e_done = 0;

    always @(posedge clk) begin
        if (!rst) begin
            active = 0; e_ser = 0; e_sh = 0; e_dir = 0; e_busy = 0; e_done = 0;
        end else if (!active) begin
            e_sh = 0; e_done = 0;
            if (start) begin
                active = 1; n = 0; cd = data; cm = msb_first; cp = int'(div) + 1;
                e_dir = msb_first; e_busy = 1;
            end
        end else begin
            n++;
            if (n <= W * cp) begin
                e_sh = (n % cp == 0);
                if (e_sh) e_ser = cm ? cd[W - n / cp] : cd[n / cp - 1];
            end else if (n == W * cp + 1) begin
                e_sh = 0; e_busy = 0; e_done = 1;
            end else begin
                e_done = 0; active = 0;
            end
        end
    end

    // Downstream shift register fed by the DUT
    logic [W-1:0] ds = '0;
    always @(posedge clk) if (shift_en) ds <= dir ? {ds[W-2:0], ser_out} : {ser_out, ds[W-1:1]};

    always @(negedge clk) if (chk_en) begin
        chk("ser_out", ser_out, e_ser);
        chk("shift_en", shift_en, e_sh);
        chk("dir", dir, e_dir);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        if (done) chk("downstream_out", ds, cd);
    end

    task automatic run_frame(input logic [W-1:0] d, input logic m, input logic [DW-1:0] dv,
                             input logic [W-1:0] exp_seq, input int exp_first, input int exp_done,
                             input bit meddle);
        int acc, nstr, first, dcyc;
        logic [W-1:0] seq;
        nstr = 0; first = -1; dcyc = -1; seq = '0;
        data = d; msb_first = m; div = dv; start = 1;
        @(negedge clk);
        acc = cyc; start = 0;
        chk("busy_after_accept", busy, 1);
        for (int i = 0; i < 3000 && dcyc < 0; i++) begin
            @(negedge clk);
            if (start) start = 0;
            if (shift_en) begin
                nstr++;
                seq = {seq[W-2:0], ser_out};
                if (first < 0) first = cyc - acc;
                if (meddle && nstr == 3) begin
                    start = 1; data = '1; msb_first = ~m; div = 5;
                end
            end
            if (done) begin
                dcyc = cyc - acc;
                if (meddle) start = 1;
            end
        end
        chk("done_edge", dcyc, exp_done);
        chk("strobe_count", nstr, W);
        chk("ser_sequence", seq, exp_seq);
        chk("first_strobe_edge", first, exp_first);
        chk("dir_held", dir, m);
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        chk("no_second_frame", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, d1, s2, d2, nstr, seen;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("reset_busy", busy, 0);
        chk("reset_shift_en", shift_en, 0);
        chk("reset_dir", dir, 0);
        rst = 1;
        @(negedge clk);

        run_frame(10'b1011001110, 1'b1, 8'd0, 10'b1011001110, 1, 11, 1'b0);
        run_frame(10'b1011001110, 1'b0, 8'd3, 10'b0111001101, 4, 41, 1'b1);

        // Abort after the 5th strobe
        data = 10'h2A5; msb_first = 1; div = 0; start = 1;
        @(negedge clk);
        start = 0; cnt = 0;
        for (int i = 0; i < 50 && cnt < 5; i++) begin
            @(negedge clk);
            if (shift_en) cnt++;
        end
        chk("abort_reached_5", cnt, 5);
        rst = 0;
        @(negedge clk);
        rst = 1;
        chk("abort_ser_out", ser_out, 0);
        chk("abort_shift_en", shift_en, 0);
        chk("abort_dir", dir, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (shift_en || done) seen++;
        end
        chk("abort_quiet", seen, 0);

        // start held high: back-to-back frames
        data = 10'h155; msb_first = 0; div = 0; start = 1;
        d1 = -1; s2 = -1; d2 = -1; nstr = 0;
        for (int i = 0; i < 100 && d2 < 0; i++) begin
            @(negedge clk);
            if (shift_en && d1 < 0) nstr++;
            if (shift_en && d1 >= 0 && s2 < 0) s2 = cyc;
            if (done) begin
                if (d1 < 0) d1 = cyc;
                else begin
                    d2 = cyc; start = 0;
                end
            end
        end
        chk("held_strobes", nstr, W);
        chk("held_gap", s2 - d1, 3);
        chk("held_period", d2 - d1, 13);
        start = 0;
        repeat (4) @(negedge clk);

        run_frame(10'h001, 1'b1, 8'hFF, 10'b0000000001, 256, 2561, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
